// File: rtl/usb_cmd_parser.sv
// -----------------------------------------------------------------------------
// usb_cmd_parser
//
// Frames 16-bit words from the USB slave-FIFO read engine into command packets
// (SYNC, header {base_addr, len}, len payload words, 16-bit checksum). The
// payload is buffered and only replayed as register writes once the checksum
// matches. Corrupt, oversized or stalled packets are dropped with a pkt_err
// pulse and leave no side effects on the register bus.
//
// Ports:
//   CLK, RST       clock / synchronous active-high reset
//   din, din_valid captured USB word and its one-cycle strobe
//   reg_addr/reg_data/reg_wr  register write port (one write per cycle in COMMIT)
//   pkt_ok         pulse after the last write of a good packet
//   pkt_err        pulse on any packet abort
//   err_count      saturating count of pkt_err pulses
//   busy           high while committing; words arriving then are dropped
//   drop_count     saturating count of words dropped while busy
//   state_monitor  current state (0 HUNT, 1 HDR, 2 DATA, 3 CSUM, 4 COMMIT)
// -----------------------------------------------------------------------------
module usb_cmd_parser #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int          MAX_LEN   = 8,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        reg_wr,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic [2:0]  state_monitor
);

  localparam int            AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            DEPTH    = 1 << AW;
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [AW-1:0] ADDR0    = '0;

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [15:0]   reg_data_q, reg_data_d;
  logic          reg_wr_q, reg_wr_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          tmo_abort;

  // Payload buffer; written in DATA, read into the registered reg_data.
  logic [15:0]   buf_mem [DEPTH];
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [15:0]   buf_wdata;

  always_ff @(posedge CLK) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= buf_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_wr_d   = 1'b0;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    tmo_abort  = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = idx_q[AW-1:0];
    buf_wdata  = din;

    // Inter-word watchdog, only armed while a packet is being framed.
    if (state_q == S_HDR || state_q == S_DATA || state_q == S_CSUM) begin
      if (din_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_abort = 1'b1;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      S_HUNT: begin
        if (din_valid && din == SYNC_WORD) begin
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (din_valid) begin
          base_d = din[15:8];
          len_d  = din[7:0];
          idx_d  = 8'd0;
          csum_d = din;
          if (din[7:0] == 8'd0 || din[7:0] > MAX_LEN8) begin
            pkt_err_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // SYNC_WORD is ordinary payload here; no resync inside a packet.
        if (din_valid) begin
          buf_we = 1'b1;
          csum_d = csum_q + din;
          idx_d  = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (din_valid) begin
          if (din == csum_q) begin
            // Issue write 0 on this edge so the first reg_wr lands in the
            // cycle right after the checksum strobe; idx then points ahead.
            state_d    = S_COMMIT;
            reg_wr_d   = 1'b1;
            reg_addr_d = base_q;
            reg_data_d = buf_mem[ADDR0];
            idx_d      = 8'd1;
          end else begin
            pkt_err_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end

      S_COMMIT: begin
        if (din_valid && drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (idx_q < len_q) begin
          reg_wr_d   = 1'b1;
          reg_addr_d = base_q + idx_q;  // 8-bit wrap is intended
          reg_data_d = buf_mem[idx_q[AW-1:0]];
          idx_d      = idx_q + 8'd1;
        end else begin
          pkt_ok_d = 1'b1;
          state_d  = S_HUNT;
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase

    // Timeout only fires on idle cycles, so it never collides with a strobe.
    if (tmo_abort) begin
      pkt_err_d = 1'b1;
      state_d   = S_HUNT;
    end

    if (pkt_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_HUNT;
      base_q     <= 8'd0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      csum_q     <= 16'd0;
      tmo_q      <= '0;
      reg_addr_q <= 8'd0;
      reg_data_q <= 16'd0;
      reg_wr_q   <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_wr_q   <= reg_wr_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign reg_addr      = reg_addr_q;
  assign reg_data      = reg_data_q;
  assign reg_wr        = reg_wr_q;
  assign pkt_ok        = pkt_ok_q;
  assign pkt_err       = pkt_err_q;
  assign err_count     = err_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign busy          = (state_q == S_COMMIT);
  assign state_monitor = state_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_usb_cmd_parser
//
// Directed bench for usb_cmd_parser. Each scenario task drives packets and
// checks outputs inline; a negedge monitor logs register writes and pulses.
// -----------------------------------------------------------------------------
module tb_usb_cmd_parser;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] din = 16'd0;
  logic        din_valid = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        reg_wr;
  logic        pkt_ok;
  logic        pkt_err;
  logic [7:0]  err_count;
  logic        busy;
  logic [7:0]  drop_count;
  logic [2:0]  state_monitor;

  int vectors = 0;
  int miscompares = 0;

  usb_cmd_parser dut (
    .CLK          (clk),
    .RST          (RST),
    .din          (din),
    .din_valid    (din_valid),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .reg_wr       (reg_wr),
    .pkt_ok       (pkt_ok),
    .pkt_err      (pkt_err),
    .err_count    (err_count),
    .busy         (busy),
    .drop_count   (drop_count),
    .state_monitor(state_monitor)
  );

  always #5 clk = ~clk;

  // Write / pulse log (only this process writes these).
  logic [7:0]  wa_q [$];
  logic [15:0] wd_q [$];
  int ok_seen  = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wa_q.push_back(reg_addr);
      wd_q.push_back(reg_data);
    end
    if (pkt_ok === 1'b1) ok_seen++;
    if (pkt_err === 1'b1) err_seen++;
  end

  logic [15:0] pl [16];

  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends SYNC, header, pl[0..len-1] and checksum (corrupted when bad=1).
  // Returns at the negedge right after the checksum word was sampled.
  task automatic send_pkt(input logic [7:0] base, input logic [7:0] len, input bit bad);
    logic [15:0] cs;
    cs = {base, len};
    for (int i = 0; i < int'(len); i++) cs = cs + pl[i];
    if (bad) cs = cs - 16'd1;
    send_word(16'hA5C3);
    send_word({base, len});
    for (int i = 0; i < int'(len); i++) send_word(pl[i]);
    send_word(cs);
    $display("pkt base=%02h len=%0d csum=%04h bad=%0d", base, len, cs, bad);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(1);
    vectors++; if (state_monitor !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_monitor); end
    vectors++; if (reg_wr !== 1'b0 || pkt_ok !== 1'b0 || pkt_err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got wr=%b ok=%b err=%b busy=%b want 0", reg_wr, pkt_ok, pkt_err, busy); end
    vectors++; if (err_count !== 8'd0 || drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_counts: got err=%0d drop=%0d want 0", err_count, drop_count); end
    vectors++; if (reg_addr !== 8'd0 || reg_data !== 16'd0) begin miscompares++; $display("FAIL reset_bus: got %02h/%04h want 00/0000", reg_addr, reg_data); end
  endtask

  task automatic test_good_packet();
    send_word(16'hA5C3);
    send_word(16'h1003);
    send_word(16'h0011);
    send_word(16'h0022);
    send_word(16'h0033);
    send_word(16'h1069);
    $display("pkt base=10 len=3 csum=1069 (spec vector)");
    vectors++; if (reg_wr !== 1'b1 || reg_addr !== 8'h10 || reg_data !== 16'h0011) begin miscompares++; $display("FAIL good_w0: got wr=%b %02h/%04h want 1 10/0011", reg_wr, reg_addr, reg_data); end
    vectors++; if (busy !== 1'b1 || state_monitor !== 3'd4) begin miscompares++; $display("FAIL good_busy: got busy=%b st=%0d want 1/4", busy, state_monitor); end
    @(negedge clk);
    vectors++; if (reg_wr !== 1'b1 || reg_addr !== 8'h11 || reg_data !== 16'h0022) begin miscompares++; $display("FAIL good_w1: got wr=%b %02h/%04h want 1 11/0022", reg_wr, reg_addr, reg_data); end
    @(negedge clk);
    vectors++; if (reg_wr !== 1'b1 || reg_addr !== 8'h12 || reg_data !== 16'h0033) begin miscompares++; $display("FAIL good_w2: got wr=%b %02h/%04h want 1 12/0033", reg_wr, reg_addr, reg_data); end
    @(negedge clk);
    vectors++; if (reg_wr !== 1'b0 || pkt_ok !== 1'b1 || state_monitor !== 3'd0) begin miscompares++; $display("FAIL good_done: got wr=%b ok=%b st=%0d want 0/1/0", reg_wr, pkt_ok, state_monitor); end
    vectors++; if (reg_addr !== 8'h12 || reg_data !== 16'h0033) begin miscompares++; $display("FAIL good_hold: got %02h/%04h want 12/0033", reg_addr, reg_data); end
    @(negedge clk);
    vectors++; if (pkt_ok !== 1'b0 || err_count !== 8'd0) begin miscompares++; $display("FAIL good_after: got ok=%b err_count=%0d want 0/0", pkt_ok, err_count); end
  endtask

  task automatic test_bad_checksum();
    int s;
    int ok0;
    s = wa_q.size();
    send_word(16'hA5C3);
    send_word(16'h1003);
    send_word(16'h0011);
    send_word(16'h0022);
    send_word(16'h0033);
    send_word(16'h1068);
    $display("pkt base=10 len=3 csum=1068 (corrupt)");
    vectors++; if (pkt_err !== 1'b1 || state_monitor !== 3'd0) begin miscompares++; $display("FAIL bad_err: got err=%b st=%0d want 1/0", pkt_err, state_monitor); end
    wait_cyc(5);
    vectors++; if (wa_q.size() != s) begin miscompares++; $display("FAIL bad_nowrite: got %0d writes want 0", wa_q.size() - s); end
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL bad_errcount: got %0d want 1", err_count); end
    // The next good packet must still be accepted.
    ok0 = ok_seen;
    pl[0] = 16'hBEEF;
    send_pkt(8'h30, 8'd1, 1'b0);
    wait_cyc(4);
    vectors++; if (wa_q.size() != s + 1 || wa_q[s] !== 8'h30 || wd_q[s] !== 16'hBEEF) begin miscompares++; $display("FAIL bad_recover: got n=%0d %02h/%04h want 1 30/beef", wa_q.size() - s, wa_q[s], wd_q[s]); end
    vectors++; if (ok_seen != ok0 + 1) begin miscompares++; $display("FAIL bad_recover_ok: got %0d pkt_ok want 1", ok_seen - ok0); end
  endtask

  task automatic test_length_limits();
    int s;
    int e0;
    logic [7:0] ea [3];
    e0 = int'(err_count);
    send_word(16'hA5C3);
    send_word(16'h0500);
    vectors++; if (pkt_err !== 1'b1 || state_monitor !== 3'd0) begin miscompares++; $display("FAIL len0: got err=%b st=%0d want 1/0", pkt_err, state_monitor); end
    send_word(16'hA5C3);
    send_word(16'h0509);
    vectors++; if (pkt_err !== 1'b1 || state_monitor !== 3'd0) begin miscompares++; $display("FAIL len9: got err=%b st=%0d want 1/0", pkt_err, state_monitor); end
    wait_cyc(1);
    vectors++; if (int'(err_count) != e0 + 2) begin miscompares++; $display("FAIL len_errcount: got %0d want %0d", err_count, e0 + 2); end
    // Maximum length packet.
    s = wa_q.size();
    for (int i = 0; i < 8; i++) pl[i] = 16'h0100 + 16'(i * 17);
    send_pkt(8'h20, 8'd8, 1'b0);
    wait_cyc(10);
    vectors++; if (wa_q.size() != s + 8) begin miscompares++; $display("FAIL len8_count: got %0d writes want 8", wa_q.size() - s); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (wa_q[s+i] !== 8'(8'h20 + i) || wd_q[s+i] !== pl[i]) begin miscompares++; $display("FAIL len8_w%0d: got %02h/%04h want %02h/%04h", i, wa_q[s+i], wd_q[s+i], 8'(8'h20 + i), pl[i]); end
    end
    // Address wrap.
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    s = wa_q.size();
    pl[0] = 16'h000A; pl[1] = 16'h000B; pl[2] = 16'h000C;
    send_pkt(8'hFE, 8'd3, 1'b0);
    wait_cyc(5);
    vectors++; if (wa_q.size() != s + 3) begin miscompares++; $display("FAIL wrap_count: got %0d writes want 3", wa_q.size() - s); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (wa_q[s+i] !== ea[i]) begin miscompares++; $display("FAIL wrap_a%0d: got %02h want %02h", i, wa_q[s+i], ea[i]); end
    end
  endtask

  task automatic test_garbage_resync();
    int s;
    int e0;
    e0 = err_seen;
    s = wa_q.size();
    send_word(16'h1234);
    send_word(16'hFFFF);
    vectors++; if (state_monitor !== 3'd0 || err_seen != e0) begin miscompares++; $display("FAIL garbage_silent: got st=%0d errs=%0d want 0/0", state_monitor, err_seen - e0); end
    pl[0] = 16'hA5C3; pl[1] = 16'h0001;
    send_pkt(8'h40, 8'd2, 1'b0);
    wait_cyc(4);
    vectors++; if (wa_q.size() != s + 2) begin miscompares++; $display("FAIL resync_count: got %0d writes want 2", wa_q.size() - s); end
    vectors++; if (wa_q[s] !== 8'h40 || wd_q[s] !== 16'hA5C3) begin miscompares++; $display("FAIL sync_as_data: got %02h/%04h want 40/a5c3", wa_q[s], wd_q[s]); end
    vectors++; if (wa_q[s+1] !== 8'h41 || wd_q[s+1] !== 16'h0001) begin miscompares++; $display("FAIL resync_w1: got %02h/%04h want 41/0001", wa_q[s+1], wd_q[s+1]); end
  endtask

  task automatic test_commit_overlap();
    int s;
    s = wa_q.size();
    for (int i = 0; i < 8; i++) pl[i] = 16'h5000 + 16'(i);
    send_pkt(8'h80, 8'd8, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL overlap_busy: got %b want 1", busy); end
    send_word(16'hA5C3);
    send_word(16'hA5C3);
    send_word(16'h0301);
    wait_cyc(6);
    vectors++; if (drop_count !== 8'd3) begin miscompares++; $display("FAIL overlap_drops: got %0d want 3", drop_count); end
    vectors++; if (busy !== 1'b0 || state_monitor !== 3'd0) begin miscompares++; $display("FAIL overlap_end: got busy=%b st=%0d want 0/0", busy, state_monitor); end
    vectors++; if (wa_q.size() != s + 8) begin miscompares++; $display("FAIL overlap_count: got %0d writes want 8", wa_q.size() - s); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (wa_q[s+i] !== 8'(8'h80 + i) || wd_q[s+i] !== 16'(16'h5000 + i)) begin miscompares++; $display("FAIL overlap_w%0d: got %02h/%04h want %02h/%04h", i, wa_q[s+i], wd_q[s+i], 8'(8'h80 + i), 16'(16'h5000 + i)); end
    end
  endtask

  task automatic test_timeout();
    int i;
    int e0;
    e0 = int'(err_count);
    send_word(16'hA5C3);
    send_word(16'h0302);
    i = 0;
    while (pkt_err !== 1'b1 && i < 1100) begin
      @(negedge clk);
      i++;
    end
    $display("timeout pulse after %0d idle cycles", i);
    vectors++; if (i < 1020 || i > 1028) begin miscompares++; $display("FAIL timeout_delay: got %0d idle cycles want ~1024", i); end
    vectors++; if (state_monitor !== 3'd0) begin miscompares++; $display("FAIL timeout_state: got %0d want 0", state_monitor); end
    @(negedge clk);
    vectors++; if (int'(err_count) != e0 + 1) begin miscompares++; $display("FAIL timeout_errcount: got %0d want %0d", err_count, e0 + 1); end
  endtask

  task automatic test_reset_mid_packet();
    int s;
    int e0;
    s = wa_q.size();
    send_word(16'hA5C3);
    send_word(16'h0302);
    send_word(16'h0001);
    vectors++; if (state_monitor !== 3'd2) begin miscompares++; $display("FAIL mid_state: got %0d want 2", state_monitor); end
    e0 = err_seen;
    RST = 1'b1;
    wait_cyc(2);
    RST = 1'b0;
    wait_cyc(1);
    vectors++; if (state_monitor !== 3'd0 || pkt_err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got st=%0d err=%b busy=%b want 0", state_monitor, pkt_err, busy); end
    vectors++; if (err_count !== 8'd0 || drop_count !== 8'd0) begin miscompares++; $display("FAIL mid_counts: got err=%0d drop=%0d want 0", err_count, drop_count); end
    vectors++; if (reg_addr !== 8'd0 || reg_data !== 16'd0 || reg_wr !== 1'b0) begin miscompares++; $display("FAIL mid_bus: got %02h/%04h wr=%b want 0", reg_addr, reg_data, reg_wr); end
    // Remainder of the aborted packet must be ignored in HUNT.
    send_word(16'h0002);
    send_word(16'h0308);
    wait_cyc(4);
    vectors++; if (wa_q.size() != s || err_seen != e0 || err_count !== 8'd0) begin miscompares++; $display("FAIL mid_tail: got writes=%0d errs=%0d err_count=%0d want 0", wa_q.size() - s, err_seen - e0, err_count); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_length_limits();
    test_garbage_resync();
    test_commit_overlap();
    test_timeout();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
